aurora_link_supervisor: RTL and testbench

//  Bring-up/recovery sequencer for the shared-QPLL dual Aurora 64b66b link (SMA master + SFP slave).

---
 rtl/aurora_link_supervisor.sv | 184 ++++++++++++++++++
 tb/tb_aurora_link_supervisor.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_link_supervisor.sv
// Bring-up / recovery sequencer for a shared-QPLL dual Aurora 64b66b link.
// Drives the joint PMA_INIT/RESET_PB pair, waits for both channels up, gates router port resets.
//
// Ports:
//   i_clk           init clock
//   i_sys_rst       synchronous active-high reset
//   i_dcm_locked    clocking locked; low forces IDLE
//   i_ch_up[1:0]    channel_up {SFP,SMA}
//   i_force_retrain single-cycle request to restart bring-up
//   o_pma_init      PMA_INIT to both cores
//   o_reset_pb      reset_pb to master core
//   o_link_ready    per-port link usable
//   o_pe_rst        per-port router reset (= ~o_link_ready)
//   o_fail          retries exhausted
//   o_retry_cnt     timeouts since last RUN
//   o_drop_cnt      RUN->retrain drops, saturating
//
// Build option: define AURORA_SUP_STATS_EN to expose o_retry_cnt / o_drop_cnt;
// otherwise both read 0 (retry limiting still works internally).
module aurora_link_supervisor #(
  parameter int CNT_W      = 24,
  parameter int PMA_CYC    = 1000,
  parameter int PB_CYC     = 100,
  parameter int DEBOUNCE   = 16,
  parameter int UP_TIMEOUT = 5000000,
  parameter int MAX_RETRY  = 7
) (
  input  logic       i_clk,
  input  logic       i_sys_rst,
  input  logic       i_dcm_locked,
  input  logic [1:0] i_ch_up,
  input  logic       i_force_retrain,
  output logic       o_pma_init,
  output logic       o_reset_pb,
  output logic [1:0] o_link_ready,
  output logic [1:0] o_pe_rst,
  output logic       o_fail,
  output logic [3:0] o_retry_cnt,
  output logic [7:0] o_drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PMA,
    S_PB,
    S_WAIT,
    S_RUN,
    S_FAIL
  } state_t;

  localparam int DEB_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);

  localparam logic [CNT_W-1:0] PMA_LAST = CNT_W'(PMA_CYC - 1);
  localparam logic [CNT_W-1:0] PB_LAST  = CNT_W'(PB_CYC - 1);
  localparam logic [CNT_W-1:0] UP_LAST  = CNT_W'(UP_TIMEOUT - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);
  localparam logic [3:0]       MAX_R    = 4'(MAX_RETRY);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [DEB_W-1:0] r_deb;
  logic [3:0]       r_retry;
  logic             r_pma_init;
  logic             r_reset_pb;
  logic [1:0]       r_link_ready;
  logic [1:0]       r_pe_rst;
  logic             r_fail;

  state_t     w_nxt;
  logic [3:0] w_retry_nxt;
  logic       w_drop_evt;
  logic       w_ch_ok;
  logic       w_force_ok;

  assign w_ch_ok = (i_ch_up == 2'b11);

  // Retrain requests are only honoured once PMA has finished its hold.
  assign w_force_ok = i_force_retrain &&
                      (r_state == S_PB || r_state == S_WAIT ||
                       r_state == S_RUN || r_state == S_FAIL);

  always_comb begin
    w_nxt       = r_state;
    w_retry_nxt = r_retry;
    w_drop_evt  = 1'b0;
    if (!i_dcm_locked) begin
      w_nxt = S_IDLE;
    end else if (w_force_ok) begin
      w_nxt       = S_PMA;
      w_retry_nxt = 4'd0;
    end else begin
      unique case (r_state)
        S_IDLE: w_nxt = S_PMA;
        S_PMA: begin
          if (r_cnt == PMA_LAST) w_nxt = S_PB;
        end
        S_PB: begin
          if (r_cnt == PB_LAST) w_nxt = S_WAIT;
        end
        S_WAIT: begin
          // Up detection beats a timeout on the same edge.
          if (w_ch_ok && r_deb == DEB_LAST) begin
            w_nxt       = S_RUN;
            w_retry_nxt = 4'd0;
          end else if (r_cnt == UP_LAST) begin
            w_retry_nxt = (r_retry == 4'hF) ? r_retry : r_retry + 4'd1;
            w_nxt       = (r_retry < MAX_R) ? S_PMA : S_FAIL;
          end
        end
        S_RUN: begin
          if (!w_ch_ok && r_deb == DEB_LAST) begin
            w_nxt      = S_PMA;
            w_drop_evt = 1'b1;
          end
        end
        S_FAIL: w_nxt = S_FAIL;
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_sys_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_deb        <= '0;
      r_retry      <= 4'd0;
      r_pma_init   <= 1'b1;
      r_reset_pb   <= 1'b1;
      r_link_ready <= 2'b00;
      r_pe_rst     <= 2'b11;
      r_fail       <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_retry <= w_retry_nxt;
      if (w_nxt != r_state) begin
        r_cnt <= '0;
        r_deb <= '0;
      end else begin
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        if (r_state == S_WAIT)
          r_deb <= w_ch_ok ? r_deb + 1'b1 : '0;
        else if (r_state == S_RUN)
          r_deb <= !w_ch_ok ? r_deb + 1'b1 : '0;
        else
          r_deb <= '0;
      end
      // Outputs decode the next state so they line up with the state register.
      r_pma_init   <= (w_nxt == S_IDLE) || (w_nxt == S_PMA) ||
                      (w_nxt == S_FAIL);
      r_reset_pb   <= (w_nxt != S_WAIT) && (w_nxt != S_RUN);
      r_link_ready <= {2{w_nxt == S_RUN}};
      r_pe_rst     <= {2{w_nxt != S_RUN}};
      r_fail       <= (w_nxt == S_FAIL);
    end
  end

  assign o_pma_init   = r_pma_init;
  assign o_reset_pb   = r_reset_pb;
  assign o_link_ready = r_link_ready;
  assign o_pe_rst     = r_pe_rst;
  assign o_fail       = r_fail;

`ifdef AURORA_SUP_STATS_EN
  logic [7:0] r_drop;

  always_ff @(posedge i_clk) begin
    if (i_sys_rst) begin
      r_drop <= 8'd0;
    end else if (w_drop_evt && r_drop != 8'hFF) begin
      r_drop <= r_drop + 8'd1;
    end
  end

  assign o_retry_cnt = r_retry;
  assign o_drop_cnt  = r_drop;
`else
  logic w_unused_drop;
  assign w_unused_drop = w_drop_evt;
  assign o_retry_cnt   = 4'd0;
  assign o_drop_cnt    = 8'd0;
`endif

endmodule

// File: tb/tb_aurora_link_supervisor.sv
// Self-checking bench for aurora_link_supervisor.
// Phase-level reference model compared every cycle, plus directed literal checks.
module tb_aurora_link_supervisor;

`ifdef AURORA_SUP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int PMA_CYC = 8;
  localparam int PB_CYC  = 4;
  localparam int DEB     = 3;
  localparam int UP_TO   = 50;
  localparam int MAX_R   = 2;

  logic       clk;
  logic       rst;
  logic       dcm;
  logic [1:0] ch;
  logic       force_rt;
  logic       pma_init;
  logic       reset_pb;
  logic [1:0] link_ready;
  logic [1:0] pe_rst;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] drop_cnt;

  aurora_link_supervisor #(
    .CNT_W(24),
    .PMA_CYC(PMA_CYC),
    .PB_CYC(PB_CYC),
    .DEBOUNCE(DEB),
    .UP_TIMEOUT(UP_TO),
    .MAX_RETRY(MAX_R)
  ) dut (
    .i_clk(clk),
    .i_sys_rst(rst),
    .i_dcm_locked(dcm),
    .i_ch_up(ch),
    .i_force_retrain(force_rt),
    .o_pma_init(pma_init),
    .o_reset_pb(reset_pb),
    .o_link_ready(link_ready),
    .o_pe_rst(pe_rst),
    .o_fail(fail),
    .o_retry_cnt(retry_cnt),
    .o_drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which phase the link is in, how long it has been there,
  // and the current run of good/bad channel samples.
  typedef enum {P_IDLE, P_PMA, P_PB, P_WAIT, P_RUN, P_FAIL} phase_e;
  phase_e ph = P_IDLE;
  int el = 0;
  int streak = 0;
  int m_retry = 0;
  int m_drop = 0;
  bit mvalid = 1'b0;

  task automatic go(input phase_e p);
    ph = p;
    el = 0;
    streak = 0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      go(P_IDLE);
      m_retry = 0;
      m_drop = 0;
      mvalid = 1'b1;
    end else if (!dcm) begin
      go(P_IDLE);
    end else if (force_rt && ph inside {P_PB, P_WAIT, P_RUN, P_FAIL}) begin
      m_retry = 0;
      go(P_PMA);
    end else begin
      case (ph)
        P_IDLE: go(P_PMA);
        P_PMA: begin
          el++;
          if (el == PMA_CYC) go(P_PB);
        end
        P_PB: begin
          el++;
          if (el == PB_CYC) go(P_WAIT);
        end
        P_WAIT: begin
          el++;
          streak = (ch == 2'b11) ? streak + 1 : 0;
          if (streak == DEB) begin
            m_retry = 0;
            go(P_RUN);
          end else if (el == UP_TO) begin
            go((m_retry < MAX_R) ? P_PMA : P_FAIL);
            m_retry = (m_retry < 15) ? m_retry + 1 : 15;
          end
        end
        P_RUN: begin
          streak = (ch != 2'b11) ? streak + 1 : 0;
          if (streak == DEB) begin
            m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            go(P_PMA);
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("m_pma_init", pma_init, int'(ph inside {P_IDLE, P_PMA, P_FAIL}));
      chk("m_reset_pb", reset_pb, int'(ph inside {P_IDLE, P_PMA, P_PB, P_FAIL}));
      chk("m_link_ready", link_ready, (ph == P_RUN) ? 3 : 0);
      chk("m_pe_rst", pe_rst, (ph == P_RUN) ? 0 : 3);
      chk("m_fail", fail, int'(ph == P_FAIL));
      chk("m_retry", retry_cnt, STATS ? m_retry : 0);
      chk("m_drop", drop_cnt, STATS ? m_drop : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int n;
  int r1;
  int r2;

  initial begin
    rst = 1'b1;
    dcm = 1'b1;
    ch = 2'b00;
    force_rt = 1'b0;
    repeat (3) tick();
    chk("rst_pma_init", pma_init, 1);
    chk("rst_reset_pb", reset_pb, 1);
    chk("rst_pe_rst", pe_rst, 3);
    chk("rst_link_ready", link_ready, 0);
    chk("rst_fail", fail, 0);

    // Bring-up
    rst = 1'b0;
    ch = 2'b11;
    tick();
    n = 0;
    while (pma_init && n < 100) begin n++; tick(); end
    chk("bring_pma_cycles", n, 8);
    n = 0;
    while (reset_pb && n < 100) begin n++; tick(); end
    chk("bring_pb_cycles", n, 4);
    n = 0;
    while (link_ready != 2'b11 && n < 100) begin n++; tick(); end
    chk("bring_up_samples", n, 3);
    chk("bring_retry", retry_cnt, 0);

    // Glitch rejection
    ch = 2'b01;
    repeat (2) tick();
    ch = 2'b11;
    repeat (3) tick();
    chk("glitch_ready", link_ready, 3);
    chk("glitch_drop", drop_cnt, 0);

    // Drop
    ch = 2'b10;
    repeat (2) tick();
    chk("drop_still_run", link_ready, 3);
    tick();
    chk("drop_pma", pma_init, 1);
    chk("drop_pe_rst", pe_rst, 3);
    chk("drop_cnt1", drop_cnt, STATS ? 1 : 0);
    ch = 2'b11;
    n = 0;
    while (link_ready != 2'b11 && n < 200) begin n++; tick(); end
    chk("drop_reseq", n, 15);

    // Retry to FAIL
    ch = 2'b00;
    repeat (3) tick();
    chk("retry_drop2", drop_cnt, STATS ? 2 : 0);
    n = 0;
    r1 = -1;
    r2 = -1;
    while (!fail && n < 1000) begin
      tick();
      n++;
      if (n == 62) r1 = retry_cnt;
      if (n == 124) r2 = retry_cnt;
    end
    chk("fail_cycles", n, 186);
    chk("retry_first", r1, STATS ? 1 : 0);
    chk("retry_second", r2, STATS ? 2 : 0);
    chk("fail_retry3", retry_cnt, STATS ? 3 : 0);
    chk("fail_pma", pma_init, 1);
    repeat (10) tick();
    chk("fail_held", fail, 1);

    // Recover from FAIL
    ch = 2'b11;
    force_rt = 1'b1;
    tick();
    force_rt = 1'b0;
    chk("rec_fail_clr", fail, 0);
    chk("rec_pma", pma_init, 1);
    n = 0;
    while (link_ready != 2'b11 && n < 200) begin n++; tick(); end
    chk("rec_run", n, 15);
    chk("rec_retry", retry_cnt, 0);
    chk("rec_drop", drop_cnt, STATS ? 2 : 0);

    // DCM loss mid-PB, with a simultaneous retrain request
    force_rt = 1'b1;
    tick();
    force_rt = 1'b0;
    repeat (10) tick();
    chk("dcm_in_pb_pma", pma_init, 0);
    chk("dcm_in_pb_rpb", reset_pb, 1);
    dcm = 1'b0;
    force_rt = 1'b1;
    tick();
    chk("dcm_idle_pma", pma_init, 1);
    chk("dcm_idle_rpb", reset_pb, 1);
    dcm = 1'b1;
    force_rt = 1'b0;
    n = 0;
    while (pma_init && n < 100) begin n++; tick(); end
    chk("dcm_relock_pma", n, 9);
    n = 0;
    while (link_ready != 2'b11 && n < 100) begin n++; tick(); end
    chk("dcm_run", n, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
